ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, number of 32-bit words in the backing array.
REQ-002 Parameter WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs  input  1  chip select from CPU.
REQ-006 we  input  1  write request.
REQ-007 oe  input  1  read request.
REQ-008 address  input  32  byte address.
REQ-009 data_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 ram_data_in  input  32  write data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 ram_data_into_mcu  output  32  read data, full aligned word.
REQ-012 ram_ready  output  1  one-cycle completion strobe.
REQ-013 err  output  1  one-cycle error strobe, coincident with ram_ready.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Request valid when cs & (we | oe); we has priority when both are high.
REQ-016 FSM states: IDLE, WAIT, ACCESS, DONE, RECOVER.
REQ-017 IDLE: on valid request, latch address, data_size, ram_data_in, we; go to WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-018 WAIT: counter loaded with WAIT_CYCLES-1, decrements each cycle; go to ACCESS on the cycle it reads 0.
REQ-019 ACCESS: perform the array read or write with latched values; go to DONE.
REQ-020 DONE: ram_ready=1 for exactly this cycle; read data valid on ram_data_into_mcu this cycle and held until the next read completes; go to RECOVER.
REQ-021 RECOVER: one idle cycle; go to IDLE; requests are ignored here.
REQ-022 Latency accept-edge to ram_ready high = WAIT_CYCLES+2 cycles; continuously held request gives one transaction every WAIT_CYCLES+4 cycles.
REQ-023 Input changes after acceptance do not affect the transaction in flight.
REQ-024 Word index = address[31:2]; index >= DEPTH_WORDS is out of range.
REQ-025 Byte lane enables: byte -> lane address[1:0]; halfword -> lanes {address[1],0} and {address[1],1}; word -> all four.
REQ-026 Writes shift right-aligned data into the enabled lanes; disabled lanes keep their contents.
REQ-027 Reads always return the whole aligned word regardless of data_size.
REQ-028 Misaligned access (halfword with address[0]=1, word with address[1:0]!=0) or data_size=11: err=1, write suppressed, read returns the aligned word.
REQ-029 Out-of-range access: err=1, write dropped, read returns 32'h0.
REQ-030 ram_ready and err are never asserted outside DONE.

Reset
REQ-031 rst asserted forces IDLE immediately: ram_ready=0, err=0, busy=0, ram_data_into_mcu=0, wait counter=0.
REQ-032 Reset mid-transaction abandons it; a pending write not yet in ACCESS is not performed.
REQ-033 Array contents are not cleared by reset.
REQ-034 The first request is accepted on the first rising edge after rst deasserts.

Structure
REQ-035 A shared package holds the data_size encodings, the FSM state encoding, and the lane-enable function.
REQ-036 One sub-module, ram_responder_array: a DEPTH_WORDS x 32 synchronous array with 4 byte write enables and registered read.

Verification
REQ-037 WAIT_CYCLES=2: word write 0xDEADBEEF to 0x10, then word read 0x10 -> ram_ready 4 cycles after each accept, read returns 0xDEADBEEF, err=0.
REQ-038 Word 0x11223344 at 0x20; byte write 0xAA to 0x22; halfword write 0x5566 to 0x20 -> read 0x20 returns 0x11AA5566.
REQ-039 Halfword write to 0x21 or data_size=11 -> err=1 with ram_ready, memory unchanged.
REQ-040 Read at word index DEPTH_WORDS -> err=1, data 0x0; write there -> err=1, no aliasing into index 0.
REQ-041 cs held high with oe=1 for 20 cycles, WAIT_CYCLES=0 -> ram_ready every 4 cycles, never two consecutive cycles high.
REQ-042 rst pulsed while in WAIT of a write -> outputs zero, busy=0, later read shows the old value; next request completes normally.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// Shared encodings for the RAM responder: access sizes, FSM states and
// the byte-lane / alignment helpers used by the top level.
package ram_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DONE    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      SIZE_BYTE: lanes = 4'b0001 << addr_lo;
      SIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lanes = 4'b1111;
      default:   lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

  // Reserved size is treated like a misaligned access: flagged, never written.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_responder_array.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered read.
// Contents have no reset so they survive a responder reset.
module ram_responder_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] wr_idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[rd_idx];
  end

endmodule

// File: rtl/ram_responder.sv
// CPU-facing RAM responder: accepts one request, inserts WAIT_CYCLES wait
// states, performs the access and strobes ram_ready (and err) for one cycle.
//
// Handshake: a request is presented when cs & (we | oe) and is taken on the
// rising edge while busy is low; completion is the single-cycle ram_ready
// strobe, and no new request is taken until busy drops again.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic        oe,
  input  logic [31:0] address,
  input  logic [1:0]  data_size,
  input  logic [31:0] ram_data_in,
  output logic [31:0] ram_data_into_mcu,
  output logic        ram_ready,
  output logic        err,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L   = DEPTH_WORDS;
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        we_q;

  logic        req_valid;
  logic        in_range_q;
  logic        bad_q;
  logic [3:0]  lanes_q;
  logic [31:0] wdata_rep;
  logic [3:0]  arr_be;
  logic [AW-1:0] rd_idx;
  logic [31:0] arr_rdata;

  assign req_valid  = cs & (we | oe);
  assign in_range_q = ({2'b00, addr_q[31:2]} < DEPTH_L);
  assign bad_q      = misaligned(size_q, addr_q[1:0]) | ~in_range_q;
  assign lanes_q    = lane_enable(size_q, addr_q[1:0]);
  assign state_dbg  = state;

  // Replicating the right-aligned data lets the lane enables pick the slot.
  always_comb begin
    wdata_rep = wdata_q;
    case (size_q)
      SIZE_BYTE: wdata_rep = {4{wdata_q[7:0]}};
      SIZE_HALF: wdata_rep = {2{wdata_q[15:0]}};
      default:   wdata_rep = wdata_q;
    endcase
  end

  assign arr_be = (state == ST_ACCESS && we_q && !bad_q) ? lanes_q : 4'b0000;

  // Read index follows the incoming address in IDLE so the registered read
  // is ready in ACCESS even with no wait states.
  assign rd_idx = (state == ST_IDLE) ? address[AW+1:2] : addr_q[AW+1:2];

  ram_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk   (clk),
    .wr_idx(addr_q[AW+1:2]),
    .be    (arr_be),
    .wdata (wdata_rep),
    .rd_idx(rd_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      wait_cnt          <= 4'd0;
      addr_q            <= 32'd0;
      size_q            <= SIZE_BYTE;
      wdata_q           <= 32'd0;
      we_q              <= 1'b0;
      ram_data_into_mcu <= 32'd0;
      ram_ready         <= 1'b0;
      err               <= 1'b0;
      busy              <= 1'b0;
    end else begin
      ram_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= address;
            size_q  <= data_size;
            wdata_q <= ram_data_in;
            we_q    <= we;
            busy    <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_ACCESS;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_ACCESS: begin
          state     <= ST_DONE;
          ram_ready <= 1'b1;
          err       <= bad_q;
          if (!we_q) ram_data_into_mcu <= in_range_q ? arr_rdata : 32'd0;
        end
        ST_DONE: begin
          state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a vector table of single transactions
// plus hand-written reset, back-to-back and zero-wait sequences.
module tb_ram_responder;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;
  localparam int         W2_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, we = 1'b0, oe = 1'b0;
  logic [31:0] address = 32'd0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] ram_data_in = 32'd0;
  logic [31:0] ram_data_into_mcu;
  logic        ram_ready, err, busy;
  logic [2:0]  state_dbg;

  logic        cs0 = 1'b0, oe0 = 1'b0;
  logic [31:0] rdata0;
  logic        ready0, err0, busy0;
  logic [2:0]  state_dbg0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .oe(oe), .address(address),
    .data_size(data_size), .ram_data_in(ram_data_in),
    .ram_data_into_mcu(ram_data_into_mcu), .ram_ready(ram_ready), .err(err),
    .busy(busy), .state_dbg(state_dbg)
  );

  ram_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .cs(cs0), .we(1'b0), .oe(oe0), .address(32'h10),
    .data_size(SZ_W), .ram_data_in(32'd0),
    .ram_data_into_mcu(rdata0), .ram_ready(ready0), .err(err0),
    .busy(busy0), .state_dbg(state_dbg0)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drives one request, scrambles the inputs right after acceptance, and
  // returns the completion data, err and accept-to-ready latency in cycles.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat);
    cs = 1'b1; we = w; oe = ~w; address = a; data_size = sz; ram_data_in = d;
    lat = 0; rd = 32'hx; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        cs = 1'b0; we = ~w; oe = w; address = a ^ 32'h0000_0ff4;
        data_size = $urandom_range(0, 3); ram_data_in = ~d;
      end
      if (ram_ready) begin
        lat = i; rd = ram_data_into_mcu; e = err;
        break;
      end
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL txn_timeout addr=%h got=no_ready exp=ready", a);
    end else begin
      @(posedge clk); #1;
      check("ready_one_cycle", {30'd0, ram_ready, err}, 32'd0);
      for (int i = 0; i < 5 && busy; i++) begin
        @(posedge clk); #1;
      end
      check("back_to_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n_ready;
    logic        prev_ready;

    vecs.push_back('{1'b1, 32'h10,   SZ_W, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h10,   SZ_W, 32'h0,        1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h20,   SZ_W, 32'h11223344, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h22,   SZ_B, 32'h000000AA, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h20,   SZ_H, 32'h00005566, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   SZ_W, 32'h0,        1'b0, 32'h11AA5566});
    vecs.push_back('{1'b1, 32'h21,   SZ_H, 32'h0000FFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h20,   SZ_R, 32'hFFFFFFFF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   SZ_B, 32'h0,        1'b0, 32'h11AA5566});
    vecs.push_back('{1'b0, 32'h23,   SZ_W, 32'h0,        1'b1, 32'h11AA5566});
    vecs.push_back('{1'b1, 32'h13,   SZ_B, 32'h00000077, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h12,   SZ_H, 32'h0,        1'b0, 32'h77ADBEEF});
    vecs.push_back('{1'b1, 32'h0,    SZ_W, 32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h1000, SZ_W, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h1000, SZ_W, 32'hCAFEF00D, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    SZ_W, 32'h0,        1'b0, 32'h12345678});

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {ram_data_into_mcu[30:0], ram_ready}, 32'd0);
    check("rst_busy_err", {30'd0, busy, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First vector starts straight away: accepted on the first edge after reset.
    foreach (vecs[k]) begin
      do_txn(vecs[k].w, vecs[k].addr, vecs[k].size, vecs[k].wdata, rd, e, lat);
      check($sformatf("lat_v%0d", k), lat, W2_LAT);
      check($sformatf("err_v%0d", k), {31'd0, e}, {31'd0, vecs[k].exp_err});
      if (!vecs[k].w) check($sformatf("rdata_v%0d", k), rd, vecs[k].exp_rd);
    end

    // Reset during the wait states of a write abandons it.
    do_txn(1'b1, 32'h30, SZ_W, 32'hAAAAAAAA, rd, e, lat);
    do_txn(1'b0, 32'h30, SZ_W, 32'h0, rd, e, lat);
    check("pre_rst_read", rd, 32'hAAAAAAAA);
    cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'h30; data_size = SZ_W;
    ram_data_in = 32'h55555555;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    check("in_wait_state", {29'd0, state_dbg}, 32'd1);
    rst = 1'b1;
    #2;
    check("midrst_data", ram_data_into_mcu, 32'd0);
    check("midrst_flags", {29'd0, ram_ready, err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b0, 32'h30, SZ_W, 32'h0, rd, e, lat);
    check("post_rst_read", rd, 32'hAAAAAAAA);
    check("post_rst_lat", lat, W2_LAT);
    check("post_rst_err", {31'd0, e}, 32'd0);

    // Zero-wait instance with a request held continuously for 20 cycles.
    @(posedge clk); #1;
    cs0 = 1'b1; oe0 = 1'b1;
    n_ready = 0; prev_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_ready_c%0d", i), {31'd0, ready0}, {31'd0, (i % 4) == 2});
      if (ready0 && prev_ready) begin
        checks++; failures++;
        $display("FAIL held_double_ready cycle=%0d got=1 exp=0", i);
      end
      if (ready0) n_ready++;
      prev_ready = ready0;
    end
    cs0 = 1'b0; oe0 = 1'b0;
    check("held_ready_count", n_ready, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
